// File: rtl/yuv_stream_pkg.sv
// yuv_stream_pkg: shared widths, entry tag positions and read-FSM states
package yuv_stream_pkg;
    localparam int YUV_WORD_W = 64;
    localparam int BEAT_W     = 32;
    localparam int ENTRY_W    = 67;
    localparam int SOF        = 66;
    localparam int SOL        = 65;
    localparam int EOL        = 64;
    typedef enum logic [1:0] {ST_EMPTY, ST_HI, ST_LO} rd_state_t;
endpackage

// File: rtl/yuv_word_fifo.sv
// yuv_word_fifo: synchronous FIFO of tagged words with a look-ahead head
module yuv_word_fifo
    import yuv_stream_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [ENTRY_W-1:0]          din_i,
    output logic [ENTRY_W-1:0]          head_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [$clog2(FIFO_DEPTH):0] count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    logic [AW:0]         r_wr;
    logic [AW:0]         r_rd;
    logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (push_i) r_wr <= r_wr + 1'b1;
            if (pop_i) r_rd <= r_rd + 1'b1;
        end
    end
    // Push-on-full with a same-cycle pop overwrites the slot being retired.
    always_ff @(posedge clk_i) begin
        if (push_i) r_mem[r_wr[AW-1:0]] <= din_i;
    end
    assign count_o = r_wr - r_rd;
    assign full_o  = count_o == (AW+1)'(FIFO_DEPTH);
    assign empty_o = count_o == '0;
    assign head_o  = r_mem[r_rd[AW-1:0]];
endmodule

// File: rtl/yuv_stream_scheduler.sv
// yuv_stream_scheduler: tags YUV422 words with line/frame marks and serialises them as 32-bit beats
module yuv_stream_scheduler
    import yuv_stream_pkg::*;
#(
    parameter int WORDS_PER_LINE = 480,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  frame_start_i,
    input  logic [YUV_WORD_W-1:0] yuv_i,
    input  logic                  yuv_valid_i,
    input  logic                  out_ready_i,
    output logic [BEAT_W-1:0]     out_data_o,
    output logic                  out_valid_o,
    output logic                  out_line_start_o,
    output logic                  out_line_end_o,
    output logic                  out_frame_start_o,
    output logic                  overflow_o,
    output logic [15:0]           line_count_o,
    output logic                  idle_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] LAST = 16'(WORDS_PER_LINE - 1);
    logic [15:0]        r_wcnt;
    logic [15:0]        r_line_count;
    logic               r_sof_pend;
    logic               r_overflow;
    rd_state_t          r_state;
    rd_state_t          w_state_nxt;
    logic [15:0]        w_wcnt;
    logic               w_eol;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic [ENTRY_W-1:0] w_entry;
    logic [ENTRY_W-1:0] w_head;
    assign w_wcnt  = frame_start_i ? '0 : r_wcnt;
    assign w_eol   = w_wcnt == LAST;
    assign w_entry = {frame_start_i | r_sof_pend, w_wcnt == '0, w_eol, yuv_i};
    assign w_pop   = r_state == ST_LO && out_ready_i;
    assign w_push  = yuv_valid_i && (!w_full || w_pop);
    assign w_drop  = yuv_valid_i && !w_push;
    yuv_word_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (w_push),
        .pop_i   (w_pop),
        .din_i   (w_entry),
        .head_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );
    // Dropped words still advance the word counter so line alignment survives overflow.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wcnt       <= '0;
            r_line_count <= '0;
            r_sof_pend   <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (frame_start_i) begin
            r_wcnt       <= yuv_valid_i ? 16'd1 : 16'd0;
            r_line_count <= '0;
            r_sof_pend   <= !yuv_valid_i;
            r_overflow   <= w_drop;
        end else if (yuv_valid_i) begin
            r_wcnt     <= w_eol ? '0 : r_wcnt + 16'd1;
            r_sof_pend <= 1'b0;
            if (w_eol && r_line_count != 16'hFFFF) r_line_count <= r_line_count + 16'd1;
            if (w_drop) r_overflow <= 1'b1;
        end
    end
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) r_state <= ST_EMPTY;
        else r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt       = r_state == ST_EMPTY ? (w_empty ? ST_EMPTY : ST_HI)
                          : r_state == ST_HI    ? (out_ready_i ? ST_LO : ST_HI)
                          : !out_ready_i        ? ST_LO
                          : (w_count > CW'(1) || w_push) ? ST_HI : ST_EMPTY;
        out_valid_o       = r_state != ST_EMPTY;
        out_data_o        = r_state == ST_HI ? w_head[63:32] : r_state == ST_LO ? w_head[31:0] : '0;
        out_line_start_o  = r_state == ST_HI && w_head[SOL];
        out_frame_start_o = r_state == ST_HI && w_head[SOF];
        out_line_end_o    = r_state == ST_LO && w_head[EOL];
        idle_o            = r_state == ST_EMPTY;
    end
    assign overflow_o   = r_overflow;
    assign line_count_o = r_line_count;
endmodule

// File: doc/yuv_stream_scheduler.md
# yuv_stream_scheduler

Output scheduler for the YUV422 converter stage. Accepts 64-bit, 4-pixel YUV422 words (byte order Y0 U0 Y1 V0 Y2 U2 Y3 V2, MSB first) with a valid strobe, tags line and frame boundaries, and buffers the words in a small FIFO. It serialises them as 32-bit pixel-pair beats under a ready/valid handshake toward the parallel output bridge, and reports overflow and line progress.

## Interface
- WORDS_PER_LINE, 480, 64-bit words per line (1920 px / 4); range 2..65535
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2
- clk_i  in  1  single clock; all logic on rising edge
- reset_i  in  1  asynchronous, active-low reset
- frame_start_i  in  1  one-cycle pulse, start of new frame
- yuv_i  in  64  YUV422 word from converter
- yuv_valid_i  in  1  yuv_i valid this cycle; no backpressure toward converter
- out_ready_i  in  1  downstream accepts beat
- out_data_o  out  32  pixel pair, {Y,U,Y,V}
- out_valid_o  out  1  out_data_o valid
- out_line_start_o  out  1  beat is first of a line
- out_line_end_o  out  1  beat is last of a line
- out_frame_start_o  out  1  beat is first of a frame
- overflow_o  out  1  sticky: word dropped
- line_count_o  out  16  lines fully written in current frame
- idle_o  out  1  FIFO empty, no beat pending

## Operation
- Write side: word counter wcnt, 0..WORDS_PER_LINE-1, advances on each accepted word and wraps to 0 after the last word.
  - Each entry stores 64 data bits + 3 tags: sol (wcnt==0), eol (wcnt==WORDS_PER_LINE-1), sof (first word after frame_start_i).
  - On eol write, line_count_o increments, saturating at 0xFFFF.
- frame_start_i: wcnt←0, line_count_o←0, sof pending←1; FIFO is NOT flushed.
  - If yuv_valid_i is in the same cycle, that word is sol+sof with wcnt=0.
  - frame_start_i mid-line truncates the line; no eol is emitted for it.
- Full: a push when count==FIFO_DEPTH and no same-cycle pop is dropped. On a drop:
  - overflow_o←1 (sticky, cleared only by frame_start_i or reset)
  - wcnt still advances, so line alignment is preserved
- Push on a full FIFO with a same-cycle pop (LO beat accepted) is accepted.
- Read FSM has states EMPTY, HI, LO.
  - EMPTY→HI when the FIFO is non-empty.
  - HI emits head[63:32]; on a transfer (valid&&ready) → LO.
  - LO emits head[31:0]; on a transfer, pop the head, then → HI if more entries remain, else → EMPTY.
- Beat tags:
  - out_line_start_o and out_frame_start_o only on the HI beat of a sol/sof entry.
  - out_line_end_o only on the LO beat of an eol entry.
- While valid && !ready, out_data_o and all tags are held stable.
- idle_o = (state==EMPTY).

## Timing
- Reset values: out_valid_o=0, all out_*start/end=0, out_data_o=0, overflow_o=0, line_count_o=0, idle_o=1, wcnt=0, FIFO empty, state EMPTY.
- Latency: a word accepted at edge k gives its HI beat valid after edge k+1, when the FIFO was empty. With ready held high, the LO beat follows after k+2.
- Throughput: one 64-bit word per 2 cycles. Sustained yuv_valid_i above 50% duty eventually overflows the FIFO.
- Reset asserted mid-beat returns everything to reset values immediately (asynchronously); the partial word is lost.
- Pointer arithmetic uses log2(FIFO_DEPTH)+1 bits; count = wr−rd, modulo.

## Structure
- Package yuv_stream_pkg holds:
  - tag bit indices (SOF=66, SOL=65, EOL=64)
  - entry width 67
  - FSM state enum
  - YUV_WORD_W=64, BEAT_W=32
- Sub-module yuv_word_fifo: synchronous FIFO, 67-bit entries, parameter FIFO_DEPTH, push/pop/full/empty/count, with head-of-queue read that needs no pop.

## Test plan
- Reset, then frame_start_i and 2 words 0x11223344_55667788, 0x99AABBCC_DDEEFF00 with WORDS_PER_LINE=2 and ready=1 → beats 0x11223344 (sol, sof), 0x55667788, 0x99AABBCC, 0xDDEEFF00 (eol); line_count_o=1.
- Backpressure: ready=0 for 5 cycles during a HI beat → out_data_o and tags stable, no beat lost or duplicated.
- Overflow: FIFO_DEPTH=8, ready=0, 10 consecutive words → words 9 and 10 dropped, overflow_o=1. Then ready=1 → exactly 16 beats. Next frame_start_i clears overflow_o.
- frame_start_i with yuv_valid_i in the same cycle, mid-line at wcnt=1 → that word tagged sol+sof, line_count_o=0, no eol on the truncated line.
- Full FIFO with push and LO-beat pop in the same cycle → push accepted, overflow_o stays 0.
- Async reset asserted during a LO beat → all outputs at reset values before the next clock edge.
